// File: rtl/multicycle_datapath.sv
// Multicycle RV32-style datapath: FETCH / EXEC / MEM / WB sequencer with an
// internal instruction memory, register file and data RAM, plus an external
// IO port with a bounded ready/timeout handshake. Addresses with bit 31 set
// are routed to the IO port; everything else goes to the data RAM.
//
// Decoder-facing encodings:
//   alu_op      : 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll,
//                 8 srl, 9 sra, 10 pass operand B, others add
//   branch_cond : 0 eq, 1 ne, 2 always (jumps), 3 never, 4 lt, 5 ge,
//                 6 ltu, 7 geu
//   data_size   : RV32 funct3 load/store size (0 b, 1 h, 2 w, 4 bu, 5 hu)
//   alu_a_src   : 0 rs1, 1 pc        alu_b_src : 0 rs2, 1 ext_imm
// The imem load port and the register debug read port exist so a host can
// place a program and inspect architectural state.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IO_TIMEOUT = 16,
  parameter int          INSTRET_W  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [2:0]           i_imm_type,
  input  logic [2:0]           i_branch_cond,
  input  logic [2:0]           i_data_size,
  input  logic                 i_data_read_en,
  input  logic                 i_data_write_en,
  input  logic                 i_reg_write_en,
  input  logic                 i_alu_a_src,
  input  logic                 i_alu_b_src,
  input  logic [1:0]           i_mem_to_reg,
  input  logic [3:0]           i_alu_op,
  output logic [6:0]           o_opcode,
  output logic [6:0]           o_funct7,
  output logic [2:0]           o_funct3,
  output logic [31:0]          o_io_address,
  output logic [31:0]          o_io_write_value,
  output logic                 o_io_read_en,
  output logic                 o_io_write_en,
  output logic [2:0]           o_io_data_size,
  input  logic [31:0]          i_io_read_value,
  input  logic                 i_io_ready,
  output logic                 o_io_error,
  output logic                 o_retire,
  output logic [INSTRET_W-1:0] o_instret,
  output logic [1:0]           o_state,
  input  logic                 i_imem_we,
  input  logic [7:0]           i_imem_addr,
  input  logic [31:0]          i_imem_wdata,
  input  logic [4:0]           i_dbg_reg_addr,
  output logic [31:0]          o_dbg_reg_data,
  output logic [31:0]          o_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(IO_TIMEOUT - 1);

  state_t               r_state;
  logic [31:0]          r_pc;
  logic [31:0]          r_ir;
  logic [31:0]          r_alur;
  logic [31:0]          r_mdr;
  logic [31:0]          r_sdr;
  logic                 r_taken;
  logic [7:0]           r_wait;
  logic                 r_io_error;
  logic [INSTRET_W-1:0] r_instret;

  logic [31:0] r_imem [0:255];
  logic [31:0] r_dmem [0:255];
  logic [31:0] r_regs [0:31];

  logic [4:0]  w_rs1_addr;
  logic [4:0]  w_rs2_addr;
  logic [4:0]  w_rd_addr;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_ext_imm;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic        w_branch_taken;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_wb_value;
  logic        w_is_io;
  logic        w_mem_io;
  logic        w_ram_we;
  logic [7:0]  w_ram_idx;
  logic [1:0]  w_byte_off;
  logic [4:0]  w_shamt;
  logic [31:0] w_ram_word;
  logic [31:0] w_ram_shifted;
  logic [31:0] w_load_data;
  logic [3:0]  w_store_mask;
  logic [31:0] w_store_data;

  assign w_rs1_addr = r_ir[19:15];
  assign w_rs2_addr = r_ir[24:20];
  assign w_rd_addr  = r_ir[11:7];
  assign w_rs1      = (w_rs1_addr == 5'd0) ? 32'd0 : r_regs[w_rs1_addr];
  assign w_rs2      = (w_rs2_addr == 5'd0) ? 32'd0 : r_regs[w_rs2_addr];
  assign w_pc_plus4 = r_pc + 32'd4;

  assign o_opcode = r_ir[6:0];
  assign o_funct3 = r_ir[14:12];
  assign o_funct7 = r_ir[31:25];

  assign o_dbg_reg_data = (i_dbg_reg_addr == 5'd0) ? 32'd0 : r_regs[i_dbg_reg_addr];
  assign o_pc           = r_pc;
  assign o_state        = r_state;
  assign o_retire       = (r_state == S_WB);
  assign o_io_error     = r_io_error;
  assign o_instret      = r_instret;

  // The IO port is only live during MEM for an IO address; it is derived from
  // the registered state so an async reset drops it immediately.
  assign w_is_io          = r_alur[31];
  assign w_mem_io         = (r_state == S_MEM) && w_is_io;
  assign o_io_read_en     = w_mem_io && i_data_read_en;
  assign o_io_write_en    = w_mem_io && i_data_write_en;
  assign o_io_address     = w_mem_io ? r_alur : 32'd0;
  assign o_io_write_value = w_mem_io ? r_sdr : 32'd0;
  assign o_io_data_size   = w_mem_io ? i_data_size : 3'd0;

  assign w_ram_we      = (r_state == S_MEM) && !w_is_io && i_data_write_en;
  assign w_ram_idx     = r_alur[9:2];
  assign w_byte_off    = r_alur[1:0];
  assign w_shamt       = {w_byte_off, 3'b000};
  assign w_ram_word    = r_dmem[w_ram_idx];
  assign w_ram_shifted = w_ram_word >> w_shamt;

  // Immediate extraction; unknown formats fall back to the I layout.
  always_comb begin
    w_ext_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    case (i_imm_type)
      3'd2:    w_ext_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      3'd3:    w_ext_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      3'd4:    w_ext_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      3'd5:    w_ext_imm = {r_ir[31:12], 12'd0};
      default: w_ext_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    endcase
  end

  // ALU with selectable operands (rs1/pc, rs2/immediate).
  always_comb begin
    w_alu_a      = i_alu_a_src ? r_pc : w_rs1;
    w_alu_b      = i_alu_b_src ? w_ext_imm : w_rs2;
    w_alu_result = w_alu_a + w_alu_b;
    case (i_alu_op)
      4'd1:    w_alu_result = w_alu_a - w_alu_b;
      4'd2:    w_alu_result = w_alu_a & w_alu_b;
      4'd3:    w_alu_result = w_alu_a | w_alu_b;
      4'd4:    w_alu_result = w_alu_a ^ w_alu_b;
      4'd5:    w_alu_result = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      4'd6:    w_alu_result = {31'd0, w_alu_a < w_alu_b};
      4'd7:    w_alu_result = w_alu_a << w_alu_b[4:0];
      4'd8:    w_alu_result = w_alu_a >> w_alu_b[4:0];
      4'd9:    w_alu_result = $signed(w_alu_a) >>> w_alu_b[4:0];
      4'd10:   w_alu_result = w_alu_b;
      default: w_alu_result = w_alu_a + w_alu_b;
    endcase
  end

  // Branch comparator on rs1/rs2; code 2 forces a jump, code 3 never branches.
  always_comb begin
    w_branch_taken = 1'b0;
    case (i_branch_cond)
      3'd0:    w_branch_taken = (w_rs1 == w_rs2);
      3'd1:    w_branch_taken = (w_rs1 != w_rs2);
      3'd2:    w_branch_taken = 1'b1;
      3'd4:    w_branch_taken = $signed(w_rs1) < $signed(w_rs2);
      3'd5:    w_branch_taken = $signed(w_rs1) >= $signed(w_rs2);
      3'd6:    w_branch_taken = w_rs1 < w_rs2;
      3'd7:    w_branch_taken = w_rs1 >= w_rs2;
      default: w_branch_taken = 1'b0;
    endcase
  end

  // RAM load alignment and sign/zero extension by access size.
  always_comb begin
    w_load_data = w_ram_shifted;
    case (i_data_size[1:0])
      2'd0:    w_load_data = i_data_size[2] ? {24'd0, w_ram_shifted[7:0]}
                                            : {{24{w_ram_shifted[7]}}, w_ram_shifted[7:0]};
      2'd1:    w_load_data = i_data_size[2] ? {16'd0, w_ram_shifted[15:0]}
                                            : {{16{w_ram_shifted[15]}}, w_ram_shifted[15:0]};
      default: w_load_data = w_ram_shifted;
    endcase
  end

  // RAM store lane replication and byte mask by access size.
  always_comb begin
    w_store_mask = 4'b1111;
    w_store_data = r_sdr;
    case (i_data_size[1:0])
      2'd0: begin
        w_store_mask = 4'b0001 << w_byte_off;
        w_store_data = {4{r_sdr[7:0]}};
      end
      2'd1: begin
        w_store_mask = 4'b0011 << w_byte_off;
        w_store_data = {2{r_sdr[15:0]}};
      end
      default: begin
        w_store_mask = 4'b1111;
        w_store_data = r_sdr;
      end
    endcase
  end

  // Writeback value select.
  always_comb begin
    w_wb_value = r_alur;
    case (i_mem_to_reg)
      2'd1:    w_wb_value = r_mdr;
      2'd2:    w_wb_value = w_pc_plus4;
      default: w_wb_value = r_alur;
    endcase
  end

  // Main sequencer: owns every architectural register except the memories.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'd0;
      r_alur     <= 32'd0;
      r_mdr      <= 32'd0;
      r_sdr      <= 32'd0;
      r_taken    <= 1'b0;
      r_wait     <= 8'd0;
      r_io_error <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_io_error <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir    <= r_imem[r_pc[9:2]];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alur  <= w_alu_result;
          r_taken <= w_branch_taken;
          r_sdr   <= w_rs2;
          r_wait  <= 8'd0;
          r_state <= (i_data_read_en || i_data_write_en) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (!w_is_io) begin
            r_mdr   <= w_load_data;
            r_state <= S_WB;
          end else if (i_io_ready) begin
            r_mdr   <= i_io_read_value;
            r_wait  <= 8'd0;
            r_state <= S_WB;
          end else if (r_wait == TIMEOUT_LAST) begin
            r_mdr      <= 32'd0;
            r_wait     <= 8'd0;
            r_io_error <= 1'b1;
            r_state    <= S_WB;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_pc      <= r_taken ? {r_alur[31:1], 1'b0} : w_pc_plus4;
          r_instret <= r_instret + INSTRET_W'(1);
          r_state   <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Register file write, restricted to WB; contents survive reset.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_WB) && i_reg_write_en && (w_rd_addr != 5'd0)) begin
      r_regs[w_rd_addr] <= w_wb_value;
    end
  end

  // Data RAM byte-masked write, restricted to a RAM-path MEM cycle.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_store_mask[b]) begin
          r_dmem[w_ram_idx][b*8 +: 8] <= w_store_data[b*8 +: 8];
        end
      end
    end
  end

  // Host program-load port into instruction memory.
  always_ff @(posedge i_clk) begin
    if (i_imem_we) begin
      r_imem[i_imem_addr] <= i_imem_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Testbench for multicycle_datapath: acts as instruction decoder and IO
// peripheral, runs a straight-line program from a vector table, then
// hand-written IO, timeout, reset-abort and branch sequences.
module tb_multicycle_datapath;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [2:0]  immType, branchCond, dataSize;
  logic        dataReadEn, dataWriteEn, regWriteEn, aluASrc, aluBSrc;
  logic [1:0]  memToReg;
  logic [3:0]  aluOp;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;
  logic [31:0] o_io_address, o_io_write_value;
  logic        o_io_read_en, o_io_write_en;
  logic [2:0]  o_io_data_size;
  logic [31:0] ioReadValue = 32'h0000_1234;
  logic        ioReady = 1'b0;
  logic        o_io_error, o_retire;
  logic [31:0] o_instret;
  logic [1:0]  o_state;
  logic        imemWe = 1'b0;
  logic [7:0]  imemAddr = 8'd0;
  logic [31:0] imemWdata = 32'd0;
  logic [4:0]  dbgAddr = 5'd0;
  logic [31:0] o_dbg_reg_data, o_pc;

  int errorCount = 0;
  int checkCount = 0;

  multicycle_datapath #(.RESET_PC(32'h0), .IO_TIMEOUT(4), .INSTRET_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_imm_type(immType), .i_branch_cond(branchCond), .i_data_size(dataSize),
    .i_data_read_en(dataReadEn), .i_data_write_en(dataWriteEn),
    .i_reg_write_en(regWriteEn), .i_alu_a_src(aluASrc), .i_alu_b_src(aluBSrc),
    .i_mem_to_reg(memToReg), .i_alu_op(aluOp),
    .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
    .o_io_address(o_io_address), .o_io_write_value(o_io_write_value),
    .o_io_read_en(o_io_read_en), .o_io_write_en(o_io_write_en),
    .o_io_data_size(o_io_data_size), .i_io_read_value(ioReadValue),
    .i_io_ready(ioReady), .o_io_error(o_io_error), .o_retire(o_retire),
    .o_instret(o_instret), .o_state(o_state),
    .i_imem_we(imemWe), .i_imem_addr(imemAddr), .i_imem_wdata(imemWdata),
    .i_dbg_reg_addr(dbgAddr), .o_dbg_reg_data(o_dbg_reg_data), .o_pc(o_pc)
  );

  // Free-running clock, 10 ns period.
  always #5 i_clk = ~i_clk;

  function automatic logic [3:0] aluFromF3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b111:  return 4'd2;
      3'b110:  return 4'd3;
      3'b100:  return 4'd4;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b001:  return 4'd7;
      default: return alt ? 4'd9 : 4'd8;
    endcase
  endfunction

  // Reference decoder driving the datapath's control inputs from IR fields.
  always_comb begin
    immType = 3'd1; branchCond = 3'd3; dataSize = o_funct3;
    dataReadEn = 1'b0; dataWriteEn = 1'b0; regWriteEn = 1'b0;
    aluASrc = 1'b0; aluBSrc = 1'b0; memToReg = 2'd0; aluOp = 4'd0;
    case (o_opcode)
      7'b0010011: begin
        aluBSrc = 1'b1; regWriteEn = 1'b1;
        aluOp = aluFromF3(o_funct3, o_funct7[5] && (o_funct3 == 3'b101));
      end
      7'b0110011: begin
        regWriteEn = 1'b1; aluOp = aluFromF3(o_funct3, o_funct7[5]);
      end
      7'b0000011: begin
        aluBSrc = 1'b1; dataReadEn = 1'b1; regWriteEn = 1'b1; memToReg = 2'd1;
      end
      7'b0100011: begin
        immType = 3'd2; aluBSrc = 1'b1; dataWriteEn = 1'b1;
      end
      7'b1100011: begin
        immType = 3'd3; aluASrc = 1'b1; aluBSrc = 1'b1; branchCond = o_funct3;
      end
      7'b1101111: begin
        immType = 3'd4; aluASrc = 1'b1; aluBSrc = 1'b1; branchCond = 3'd2;
        regWriteEn = 1'b1; memToReg = 2'd2;
      end
      7'b0110111: begin
        immType = 3'd5; aluBSrc = 1'b1; regWriteEn = 1'b1; aluOp = 4'd10;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
    imemWe = 1'b1; imemAddr = addr[9:2]; imemWdata = data;
    @(posedge i_clk); #1;
    imemWe = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] v);
    dbgAddr = a; #1;
    v = o_dbg_reg_data;
  endtask

  task automatic doReset();
    i_reset = 1'b1; #1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  // Runs one instruction from FETCH through WB, acting as the IO peripheral.
  // readyAt < 0: io_ready always high; 0: never; n: high in MEM cycle n.
  task automatic applyStimulus(input int readyAt, output int lat, output int memCycles,
                               output int rdEn, output int wrEn, output int errPulses,
                               output logic errAtRetire, output logic [31:0] ioAddr,
                               output logic [31:0] ioWval, output logic [2:0] ioSize,
                               output int badOutside);
    int n;
    bit done;
    n = 1; done = 0; lat = -1; memCycles = 0; rdEn = 0; wrEn = 0; errPulses = 0;
    errAtRetire = 1'b0; ioAddr = 32'd0; ioWval = 32'd0; ioSize = 3'd0; badOutside = 0;
    while (!done) begin
      if (o_state == 2'd2) begin
        memCycles++;
        ioReady = (readyAt < 0) || (readyAt == memCycles);
        if (o_io_read_en) rdEn++;
        if (o_io_write_en) wrEn++;
        if (o_io_read_en || o_io_write_en) begin
          ioAddr = o_io_address; ioWval = o_io_write_value; ioSize = o_io_data_size;
        end
      end else begin
        ioReady = (readyAt < 0);
        if (o_io_read_en || o_io_write_en || (o_io_address != 32'd0)) badOutside++;
      end
      if (o_io_error) errPulses++;
      if (o_retire) begin
        done = 1; lat = n; errAtRetire = o_io_error;
      end
      @(posedge i_clk); #1;
      if (!done) begin
        n++;
        if (n > 60) done = 1;
      end
    end
    ioReady = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          lat;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [31:0] pcNext;
  } vec_t;

  localparam int NUM_VECS = 18;
  vec_t vecs [NUM_VECS];

  initial begin
    int lat, memCycles, rdEn, wrEn, errPulses, badOutside;
    logic errAtRetire;
    logic [31:0] ioAddr, ioWval, rv;
    logic [2:0] ioSize;

    vecs[0]  = '{32'd0,  encI(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 3, 5'd1, 32'd5, 32'd4};
    vecs[1]  = '{32'd4,  encI(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), 3, 5'd2, 32'hFFFF_FFFD, 32'd8};
    vecs[2]  = '{32'd8,  encR(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 3, 5'd3, 32'd2, 32'd12};
    vecs[3]  = '{32'd12, encR(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 3, 5'd4, 32'd8, 32'd16};
    vecs[4]  = '{32'd16, encU(20'hDEADC, 5'd5), 3, 5'd5, 32'hDEAD_C000, 32'd20};
    vecs[5]  = '{32'd20, encI(12'hEEF, 5'd5, 3'b000, 5'd5, 7'b0010011), 3, 5'd5, 32'hDEAD_BEEF, 32'd24};
    vecs[6]  = '{32'd24, encS(12'h010, 5'd5, 5'd0, 3'b010), 4, 5'd5, 32'hDEAD_BEEF, 32'd28};
    vecs[7]  = '{32'd28, encI(12'h010, 5'd0, 3'b010, 5'd6, 7'b0000011), 4, 5'd6, 32'hDEAD_BEEF, 32'd32};
    vecs[8]  = '{32'd32, encI(12'h010, 5'd0, 3'b000, 5'd7, 7'b0000011), 4, 5'd7, 32'hFFFF_FFEF, 32'd36};
    vecs[9]  = '{32'd36, encI(12'h012, 5'd0, 3'b101, 5'd8, 7'b0000011), 4, 5'd8, 32'h0000_DEAD, 32'd40};
    vecs[10] = '{32'd40, encR(7'd0, 5'd1, 5'd2, 3'b010, 5'd9), 3, 5'd9, 32'd1, 32'd44};
    vecs[11] = '{32'd44, encB(13'd8, 5'd1, 5'd2, 3'b100), 3, 5'd9, 32'd1, 32'd52};
    vecs[12] = '{32'd52, encB(13'd8, 5'd1, 5'd2, 3'b101), 3, 5'd9, 32'd1, 32'd56};
    vecs[13] = '{32'd56, encJ(21'd8, 5'd10), 3, 5'd10, 32'd60, 32'd64};
    vecs[14] = '{32'd64, encI(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011), 3, 5'd0, 32'd0, 32'd68};
    vecs[15] = '{32'd68, encR(7'd0, 5'd6, 5'd5, 3'b100, 5'd11), 3, 5'd11, 32'd0, 32'd72};
    vecs[16] = '{32'd72, encR(7'd0, 5'd4, 5'd5, 3'b111, 5'd12), 3, 5'd12, 32'd8, 32'd76};
    vecs[17] = '{32'd76, encR(7'h20, 5'd1, 5'd2, 3'b101, 5'd14), 3, 5'd14, 32'hFFFF_FFFF, 32'd80};

    // Asynchronous reset state before any clock edge.
    #2 i_reset = 1'b1;
    #1;
    checkOutput("reset_state", {30'd0, o_state}, 32'd0);
    checkOutput("reset_pc", o_pc, 32'd0);
    checkOutput("reset_instret", o_instret, 32'd0);
    checkOutput("reset_opcode", {25'd0, o_opcode}, 32'd0);
    checkOutput("reset_strobes", {28'd0, o_retire, o_io_error, o_io_read_en, o_io_write_en}, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) loadWord(vecs[i].addr, vecs[i].instr);
    loadWord(32'd48, encI(12'd77, 5'd0, 3'b000, 5'd9, 7'b0010011));
    loadWord(32'd60, encI(12'd1, 5'd0, 3'b000, 5'd10, 7'b0010011));
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    $display("[TB] table program");
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(-1, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                    ioAddr, ioWval, ioSize, badOutside);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      readReg(vecs[i].rd, rv);
      checkOutput($sformatf("vec%0d_rd", i), rv, vecs[i].rdVal);
      checkOutput($sformatf("vec%0d_pc", i), o_pc, vecs[i].pcNext);
      checkOutput($sformatf("vec%0d_instret", i), o_instret, i + 1);
      checkOutput($sformatf("vec%0d_io_quiet", i), rdEn + wrEn + badOutside, 32'd0);
    end

    $display("[TB] IO load with ready in fourth MEM cycle");
    loadWord(32'd0, encU(20'h80000, 5'd13));
    loadWord(32'd4, encI(12'd0, 5'd13, 3'b010, 5'd14, 7'b0000011));
    doReset();
    applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    applyStimulus(4, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    checkOutput("io_load_latency", lat, 32'd7);
    checkOutput("io_load_rd_en_cycles", rdEn, 32'd4);
    checkOutput("io_load_addr", ioAddr, 32'h8000_0000);
    checkOutput("io_load_size", {29'd0, ioSize}, 32'd2);
    checkOutput("io_load_no_error", errPulses, 32'd0);
    checkOutput("io_load_outside_quiet", badOutside, 32'd0);
    readReg(5'd14, rv);
    checkOutput("io_load_rd", rv, 32'h0000_1234);
    checkOutput("io_load_instret", o_instret, 32'd2);

    $display("[TB] IO timeout");
    loadWord(32'd0, encI(12'd99, 5'd0, 3'b000, 5'd15, 7'b0010011));
    loadWord(32'd4, encI(12'd0, 5'd13, 3'b010, 5'd15, 7'b0000011));
    loadWord(32'd8, encI(12'd1, 5'd0, 3'b000, 5'd16, 7'b0010011));
    doReset();
    applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    checkOutput("timeout_latency", lat, 32'd7);
    checkOutput("timeout_mem_cycles", memCycles, 32'd4);
    checkOutput("timeout_error_pulses", errPulses, 32'd1);
    checkOutput("timeout_error_in_wb", {31'd0, errAtRetire}, 32'd1);
    readReg(5'd15, rv);
    checkOutput("timeout_rd_zero", rv, 32'd0);
    applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    checkOutput("after_timeout_latency", lat, 32'd3);
    checkOutput("after_timeout_no_error", errPulses, 32'd0);
    readReg(5'd16, rv);
    checkOutput("after_timeout_rd", rv, 32'd1);
    checkOutput("after_timeout_pc", o_pc, 32'd12);

    $display("[TB] IO store, zero wait");
    loadWord(32'd0, encS(12'd4, 5'd1, 5'd13, 3'b010));
    doReset();
    applyStimulus(1, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    checkOutput("io_store_latency", lat, 32'd4);
    checkOutput("io_store_wr_en_cycles", wrEn, 32'd1);
    checkOutput("io_store_rd_en_cycles", rdEn, 32'd0);
    checkOutput("io_store_addr", ioAddr, 32'h8000_0004);
    checkOutput("io_store_value", ioWval, 32'd5);

    $display("[TB] reset during IO wait");
    loadWord(32'd0, encI(12'd42, 5'd0, 3'b000, 5'd17, 7'b0010011));
    loadWord(32'd4, encI(12'd0, 5'd13, 3'b010, 5'd17, 7'b0000011));
    doReset();
    applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                  ioAddr, ioWval, ioSize, badOutside);
    ioReady = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    checkOutput("abort_waiting", {30'd0, o_state, o_io_read_en}, 32'd5);
    #2 i_reset = 1'b1;
    #1;
    checkOutput("abort_rd_en_drop", {31'd0, o_io_read_en}, 32'd0);
    checkOutput("abort_state", {30'd0, o_state}, 32'd0);
    checkOutput("abort_pc", o_pc, 32'd0);
    checkOutput("abort_instret", o_instret, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    readReg(5'd17, rv);
    checkOutput("abort_reg_kept", rv, 32'd42);
    readReg(5'd5, rv);
    checkOutput("reset_keeps_regfile", rv, 32'hDEAD_BEEF);

    $display("[TB] branches at pc 8");
    loadWord(32'd0, encI(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011));
    loadWord(32'd4, encI(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011));
    loadWord(32'd8, encB(13'h1FF8, 5'd0, 5'd0, 3'b000));
    doReset();
    repeat (3) applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                             ioAddr, ioWval, ioSize, badOutside);
    checkOutput("beq_latency", lat, 32'd3);
    checkOutput("beq_pc", o_pc, 32'd0);
    loadWord(32'd8, encB(13'h1FF8, 5'd0, 5'd0, 3'b001));
    doReset();
    repeat (3) applyStimulus(0, lat, memCycles, rdEn, wrEn, errPulses, errAtRetire,
                             ioAddr, ioWval, ioSize, badOutside);
    checkOutput("bne_latency", lat, 32'd3);
    checkOutput("bne_pc", o_pc, 32'd12);
    checkOutput("bne_instret", o_instret, 32'd3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 RESET_PC, 32'h0000_0000, pc value loaded on reset.
REQ-002 IO_TIMEOUT, 16, maximum MEM cycles spent on one IO access before forced completion (range 1..255).
REQ-003 INSTRET_W, 32, width of the retired-instruction counter.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imm_type, branch_cond, data_size  input  3 each  decoder outputs:
- imm_type: 1 I, 2 S, 3 B, 4 J, 5 U.
- branch_cond: condition code with BranchComp encoding.
- data_size: access size.
REQ-007 data_read_en, data_write_en, reg_write_en, alu_a_src, alu_b_src  input  1 each  decoder strobes and ALU operand selects.
REQ-008 mem_to_reg  input  2  writeback select (0 ALU, 1 load data, 2 pc+4); alu_op  input  4  ALU operation.
REQ-009 opcode, funct7, funct3  output  7/7/3  fields of the instruction register IR, stable from EXEC through WB.
REQ-010 io_address, io_write_value  output  32 each  IO access address and store data.
REQ-011 io_read_en, io_write_en  output  1 each; io_data_size  output  3.
REQ-012 io_read_value  input  32  IO load data; io_ready  input  1  peripheral completion.
REQ-013 io_error  output  1  one-cycle pulse on IO timeout.
REQ-014 retire  output  1  one-cycle pulse per completed instruction; instret  output  INSTRET_W  retired-instruction count.
REQ-015 state  output  2  current state: 0 FETCH, 1 EXEC, 2 MEM, 3 WB.

Function
REQ-016 FSM transitions:
- FETCH -> EXEC.
- EXEC -> MEM if data_read_en or data_write_en, else EXEC -> WB.
- MEM -> WB on completion.
- WB -> FETCH.
REQ-017 FETCH: IR loads the instruction-memory word at pc; all decoder inputs are ignored.
REQ-018 EXEC, latched on the closing edge:
- ALU operand A is rs1 or pc; operand B is rs2 or ext_imm.
- ALUR <= ALU result.
- TAKEN <= BranchComp(rs1, rs2, branch_cond).
- SDR <= rs2.
REQ-019 ext_imm formats are unchanged from the single-cycle DatapathUnit; undefined imm_type selects the I format.
REQ-020 MEM, RAM path (address decoder is_io = 0):
- Data RAM is read or written in exactly one MEM cycle.
- Load data is latched into MDR.
- Next state is WB.
REQ-021 MEM, IO path:
- io_read_en/io_write_en, io_address = ALUR, io_write_value = SDR and io_data_size = data_size are held stable every MEM cycle until io_ready = 1 is sampled.
- On that edge, MDR <= io_read_value.
REQ-022 IO timeout:
- A wait counter counts MEM cycles.
- After IO_TIMEOUT MEM cycles with io_ready = 0: next state is WB, MDR <= 0, and io_error pulses during that WB.
REQ-023 IO wait cases:
- io_ready = 1 in the first MEM cycle gives zero wait.
- io_ready is ignored outside MEM.
- io_ready arriving in the same cycle the timeout expires counts as success, with no io_error.
REQ-024 All io/RAM enables are 0 and io_address = 0 outside MEM.
REQ-025 WB register write:
- The register file writes only in WB, and only when reg_write_en = 1 and rd != 0.
- Write value: ALUR for mem_to_reg 0 or 3, MDR for 1, pc+4 for 2.
REQ-026 WB update:
- pc <= {ALUR[31:1], 0} if TAKEN, else pc + 4.
- retire pulses.
- instret increments, wrapping modulo 2^INSTRET_W.
REQ-027 Latency:
- ALU, branch, jump: 3 cycles.
- RAM load/store: 4 cycles.
- IO access: 3 + MEM cycles, maximum 3 + IO_TIMEOUT.
REQ-028 No register, RAM or IO write occurs outside its designated state, whatever the decoder strobes.

Reset
REQ-029 While reset is high, without waiting for a clock:
- state = FETCH, pc = RESET_PC, IR = 0.
- ALUR, MDR, SDR, TAKEN, wait counter = 0.
- instret = 0; retire, io_error, all enables = 0.
REQ-030 Reset during a MEM IO wait:
- Enables drop immediately.
- The aborted instruction makes no pc or register update.
- Register-file and RAM contents are not cleared.
REQ-031 The first FETCH occurs on the first rising clk edge after reset deasserts.

Verification
REQ-032 addi x1,x0,5 at RESET_PC = 0 -> retire in cycle 3, x1 = 5, pc = 4, instret = 1.
REQ-033 sw 0xDEADBEEF to RAM 0x10, then lw from 0x10 -> each takes 4 cycles; rd = 0xDEADBEEF.
REQ-034 lw from an IO address, io_ready high in the 4th MEM cycle, io_read_value = 0x1234 -> io_read_en high for exactly 4 cycles, rd = 0x1234, retire in cycle 7.
REQ-035 IO_TIMEOUT = 4, io_ready stuck at 0 -> exactly 4 MEM cycles, one io_error pulse, rd = 0, next FETCH proceeds normally.
REQ-036 Branches:
- beq x0,x0,-8 at pc 8 -> pc = 0 after 3 cycles.
- bne x0,x0,-8 at pc 8 -> pc = 12.
REQ-037 Reset pulse mid IO wait -> io_read_en = 0 in the same cycle, pc = RESET_PC, instret = 0, state = FETCH.
